// File: rtl/shift_rotate_sequencer_if.sv
// Request/response bundle for the multi-cycle shift/rotate unit.
// The master issues start/op/data_in/amount; the slave returns busy/done/result.
interface shift_rotate_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  amount;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, data_in, amount,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, amount,
    output busy, done, result
  );
endinterface

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle SHR/SHRA/SHL/ROR/ROL unit: moves a 32-bit operand at most STEP
// bit positions per cycle under an IDLE/RUN/DONE start-busy-done handshake.
module shift_rotate_sequencer #(
  parameter int STEP = 1
) (
  input  logic                            clk,
  input  logic                            clr,
  shift_rotate_sequencer_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [4:0] STEP_V  = 5'(STEP);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  remain_q, remain_d;
  logic [31:0] work_q, work_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  step_s;
  logic [4:0]  load_remain_s;

  // SHRA refills from the current MSB each step, so chained steps compose
  // into one arithmetic shift by the total count.
  function automatic logic [31:0] move_bits(input logic [2:0] op,
                                            input logic [31:0] w,
                                            input logic [4:0] s);
    logic [31:0] r;
    case (op)
      OP_SHR:  r = w >> s;
      OP_SHRA: r = $signed(w) >>> s;
      OP_SHL:  r = w << s;
      OP_ROR:  r = (w >> s) | (w << (6'd32 - {1'b0, s}));
      OP_ROL:  r = (w << s) | (w >> (6'd32 - {1'b0, s}));
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state, datapath step and registered handshake outputs.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    remain_d      = remain_q;
    work_d        = work_q;
    step_s        = (remain_q < STEP_V) ? remain_q : STEP_V;
    load_remain_s = (bus.op > OP_ROL) ? 5'd0 : bus.amount;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          work_d   = bus.data_in;
          op_d     = bus.op;
          remain_d = load_remain_s;
          state_d  = (load_remain_s == 5'd0) ? ST_DONE : ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_d   = move_bits(op_q, work_q, step_s);
        remain_d = remain_q - step_s;
        if (remain_d == 5'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; clr abandons any in-flight operation.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      remain_q <= 5'd0;
      work_q   <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      remain_q <= remain_d;
      work_q   <= work_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = work_q;

endmodule

// File: doc/shift_rotate_sequencer.md
Name: shift_rotate_sequencer

Overview:
Multi-cycle shift/rotate execution unit for the CPU datapath ALU.
- Performs SHR, SHRA, SHL, ROR and ROL on a 32-bit operand.
- Uses a narrow STEP-bit shifter once per cycle instead of a full barrel shifter.
- Sequenced by a small FSM with a start/busy/done handshake, so the control unit can stall until the result is valid.

Parameters:
- STEP, 1, maximum bit positions moved per cycle; legal values are 1, 2, 4, 8 and 16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous and active-low; forces IDLE.
- start  in  1  request; sampled on a rising edge only when the unit is accepting.
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 are pass-through.
- data_in  in  32  operand; captured when start is accepted.
- amount  in  5  shift/rotate count, 0-31; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  working register; valid when done is high, then held.

Behaviour:
- States: IDLE, RUN, DONE. Internal registers: op_q (3), remain (5), work (32).
- Reset (clr=0, any time, asynchronous): state=IDLE, busy=0, done=0, result=0, remain=0.
  - Any in-flight operation is abandoned; no done is produced for it.
- Accepting states: IDLE and DONE. A start in RUN is ignored and not queued.
- Accepted start at edge E0:
  - work<=data_in, op_q<=op.
  - remain<=amount, except remain<=0 when op is 101-111.
  - If the loaded remain is 0, next state is DONE; otherwise next state is RUN.
- RUN, each edge:
  - s = min(STEP, remain).
  - work is moved s positions per op_q:
    - SHR: zero fill.
    - SHRA: fill with work[31].
    - SHL: zero fill.
    - ROR: bits leaving [0] enter [31].
    - ROL: bits leaving [31] enter [0].
  - remain <= remain - s.
  - If remain - s == 0, next state is DONE.
- DONE: done=1 for exactly one cycle.
  - With no start, go to IDLE.
  - With start, accept it (back-to-back, as above).
- busy is high only in RUN. done and busy are never high together.
- Latency: done is high in cycle max(1, ceil(N/STEP)+1) after the start edge, where N is the captured amount.
  - Example, STEP=1, N=4: done in the 5th cycle after start.
- result = work at all times.
  - It changes during RUN.
  - It is stable from the done cycle until the next accepted start.
- Composed SHRA steps must equal a single arithmetic shift by N: sign replication uses the current MSB.
- An amount input of 0 and pass-through ops both return data_in unchanged with done in 1 cycle.
- Inputs are don't-care outside the start-accept edge.

Test Plan:
- Directed ops, STEP=1:
  - ROL 0x80000001 by 4 -> result=0x00000018; busy high 4 cycles; done in cycle 5.
  - ROR 0x0000000F by 8 -> 0x0F000000.
  - SHR 0xF0000000 by 28 -> 0x0000000F.
- SHRA 0x80000000 by 31, STEP=1 -> 0xFFFFFFFF; done in cycle 32.
  - Repeat with SHL 0x00000001 by 31 -> 0x80000000.
- Zero-count and pass-through:
  - amount=0 with op=ROL and data 0xDEADBEEF -> done in cycle 1, result=0xDEADBEEF, busy never high.
  - op=111 with amount=9 -> same behaviour.
- Handshake: start with op=SHL, data=0x1, amount=3.
  - Re-assert start with different data in RUN -> ignored; result=0x00000008.
  - Assert start in the DONE cycle (ROR 0x1 by 1) -> accepted; next done has result=0x80000000 with no IDLE gap.
- Reset mid-operation: clr low for part of a cycle during RUN of SHL 0x1 by 20.
  - Immediately busy=0, done=0, result=0.
  - No done pulse follows; a new request after release completes correctly.
- STEP=4 build: ROL 0x12345678 by 31 -> 0x091A2B3C.
  - 8 RUN cycles, the last moving 3 bits; done in cycle 9.
  - Randomised sweep of all ops and amounts vs. a reference model, for both STEP values.
